timestep_scheduler: RTL and testbench
=====================================

Name: timestep_scheduler

Overview:
- Top-level run sequencer for the SNN core grid: steps an inference through `num_steps` timesteps.
- Each timestep runs four phases in order: input injection from the input buffer, network settle (grid idle, router buffers drained), a single tick to all cores, and collection of per-core tick-done acknowledgements.
- Signals run completion and flags cores that miss the processing deadline.

Parameters:
- NUM_CORES, 6, number of cores returning a tick-done acknowledgement
- TS_W, 16, width of timestep count and step counter
- SETTLE, 5, consecutive quiet cycles required before a tick (must be >= 1)
- TIMEOUT, 65420, maximum PROC-state cycles per timestep before forced advance
- TO_W, 17, width of timeout counter (must satisfy 2^TO_W > TIMEOUT)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle run request
- num_steps  input  TS_W  timesteps to run; sampled on accepted start
- in_valid  input  1  input buffer holds a packet for the current timestep
- in_last  input  1  qualifies in_valid: last packet of the current timestep
- in_ready  output  1  scheduler accepts an input packet this cycle
- grid_idle  input  1  all core controllers idle
- net_empty  input  1  all forward/north/local router buffers empty
- core_done  input  NUM_CORES  per-core tick-processing-finished, pulse or level
- tick  output  1  one-cycle tick to all cores
- busy  output  1  run in progress
- step_cnt  output  TS_W  completed timesteps in current/last run
- done  output  1  one-cycle run-complete pulse
- timeout_err  output  1  sticky: a timestep hit TIMEOUT

Behaviour:
- Reset (asynchronous, mid-run included): state=IDLE; tick=0, done=0, busy=0, in_ready=0, step_cnt=0, timeout_err=0; all counters and masks cleared.
- tick, done, busy are registered. in_ready is decoded from the state register only and has no combinational path from in_valid.
- Packet transfer occurs on in_valid && in_ready.
- IDLE:
  - start with num_steps != 0: latch num_steps, clear step_cnt and timeout_err, go to FEED. busy=1 from the next cycle.
  - start with num_steps == 0: done=1 next cycle, stay IDLE, busy stays 0.
- start is ignored in every state other than IDLE.
- FEED:
  - in_ready=1.
  - A transfer with in_last=1 moves to SETTLE and clears the settle counter. Transfers with in_last=0 stay in FEED.
  - With no valid packet, FEED waits indefinitely. A timestep always contains at least one packet (the one carrying in_last).
- SETTLE:
  - in_ready=0.
  - Settle counter increments each cycle grid_idle && net_empty is true; any cycle with either low resets it to 0.
  - A quiet cycle with counter == SETTLE-1 moves to TICK. Minimum dwell is SETTLE cycles.
- TICK:
  - Lasts exactly one cycle; tick=1 during the following cycle (registered).
  - Clears done mask and timeout counter; moves to PROC.
- PROC:
  - core_done is sampled only in PROC; a pulse in any other state is lost. Each cycle, mask |= core_done.
  - Timeout counter increments each cycle.
  - Exit condition: mask all ones, or timeout counter == TIMEOUT-1 (whichever is first; all-ones wins on the same cycle).
  - On timeout without all-ones: set timeout_err.
  - On exit: step_cnt += 1. If the new value == latched num_steps, go to DONE; otherwise go to FEED.
- DONE: done=1 for one cycle, busy=0 from the same cycle, state returns to IDLE. step_cnt holds its value until the next accepted start.
- tick count per run equals latched num_steps exactly. A second tick is never issued within one timestep.
- step_cnt does not wrap within a run (bounded by num_steps ≤ 2^TS_W-1).

Test Plan:
- Run and settle timing: num_steps=3, 4 packets per step, core_done=all ones 2 cycles after tick, grid_idle=net_empty=1 -> exactly 3 tick pulses; each tick is ≥SETTLE+1 cycles after the in_last transfer; done pulses once; step_cnt=3; timeout_err=0.
- Settle restart: drop net_empty for one cycle when the settle counter=3 -> tick delayed until 5 consecutive quiet cycles after the glitch.
- Staggered acknowledgements: core_done bits pulsed one at a time on different cycles (bit 5 last, 10 cycles after tick) -> advance occurs only after bit 5; step_cnt increments once.
- Timeout: core 2 never acknowledges, TIMEOUT overridden to 20 -> advance after 20 PROC cycles; timeout_err=1 and stays 1 through done; cleared on next start.
- Zero steps and start while busy: start with num_steps=0 -> done pulse, no tick, busy stays 0. start pulsed mid-run -> ignored; tick count is unchanged.
- Reset mid-run: rst_n asserted during PROC of step 2 -> all outputs return to reset values immediately. The next start runs cleanly from step_cnt=0.

Source files
------------

// File: rtl/timestep_scheduler.sv
// Timestep run sequencer for the SNN core grid: feeds input packets, waits for the
// network to settle, ticks all cores, then collects tick-done acknowledgements per step.
module timestep_scheduler #(
  parameter int NUM_CORES = 6,
  parameter int TS_W      = 16,
  parameter int SETTLE    = 5,
  parameter int TIMEOUT   = 65420,
  parameter int TO_W      = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TS_W-1:0]      num_steps,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 grid_idle,
  input  logic                 net_empty,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 tick,
  output logic                 busy,
  output logic [TS_W-1:0]      step_cnt,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FEED   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_TICK   = 3'd3;
  localparam logic [2:0] S_PROC   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [TS_W-1:0]      steps_q, steps_d;
  logic [TS_W-1:0]      step_cnt_q, step_cnt_d;
  logic [SC_W-1:0]      settle_q, settle_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic                 terr_q, terr_d;
  logic                 tick_q, done_q, busy_q, done_d;
  logic                 quiet, all_acked, to_hit;
  logic [TS_W-1:0]      step_inc;

  assign quiet     = grid_idle & net_empty;
  assign all_acked = &(mask_q | core_done);
  assign to_hit    = (to_q == TO_W'(TIMEOUT - 1));
  assign step_inc  = step_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    settle_d   = settle_q;
    to_d       = to_q;
    mask_d     = mask_q;
    terr_d     = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start && (num_steps != '0)) begin
          steps_d    = num_steps;
          step_cnt_d = '0;
          terr_d     = 1'b0;
          state_d    = S_FEED;
        end
      end
      S_FEED: begin
        if (in_valid && in_last) begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Any noisy cycle restarts the quiet-run count from zero.
        if (!quiet) begin
          settle_d = '0;
        end else if (settle_q == SC_W'(SETTLE - 1)) begin
          state_d = S_TICK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_TICK: begin
        mask_d  = '0;
        to_d    = '0;
        state_d = S_PROC;
      end
      S_PROC: begin
        mask_d = mask_q | core_done;
        to_d   = to_q + 1'b1;
        // A full mask on the timeout cycle counts as success, not a timeout.
        if (all_acked || to_hit) begin
          if (!all_acked) terr_d = 1'b1;
          step_cnt_d = step_inc;
          state_d    = (step_inc == steps_q) ? S_DONE : S_FEED;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d = (state_d == S_DONE) ||
                  ((state_q == S_IDLE) && start && (num_steps == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      steps_q    <= '0;
      step_cnt_q <= '0;
      settle_q   <= '0;
      to_q       <= '0;
      mask_q     <= '0;
      terr_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      mask_q     <= mask_d;
      terr_q     <= terr_d;
      tick_q     <= (state_q == S_TICK);
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  assign in_ready    = (state_q == S_FEED);
  assign tick        = tick_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign step_cnt    = step_cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_timestep_scheduler.sv
// Self-checking bench for timestep_scheduler: randomized runs checked cycle by cycle
// against an event-time model (quiet-run lengths, acknowledgement latencies).
module tb_timestep_scheduler;

  localparam int NC  = 6;
  localparam int TSW = 16;
  localparam int ST  = 5;
  localparam int TO  = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [TSW-1:0] num_steps = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           grid_idle = 1'b1;
  logic           net_empty = 1'b1;
  logic [NC-1:0]  core_done = '0;
  logic           in_ready, tick, busy, done, timeout_err;
  logic [TSW-1:0] step_cnt;

  int checks = 0;
  int failures = 0;
  int last_steps = 0;

  always #5 clk = ~clk;

  timestep_scheduler #(
    .NUM_CORES(NC), .TS_W(TSW), .SETTLE(ST), .TIMEOUT(TO), .TO_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .grid_idle(grid_idle), .net_empty(net_empty), .core_done(core_done),
    .tick(tick), .busy(busy), .step_cnt(step_cnt), .done(done),
    .timeout_err(timeout_err)
  );

  // mode: 0 random, 1 fixed basic, 2 settle glitch, 3 staggered acks,
  //       4 core 2 dead, 5 core 2 dead with abort in PROC of step 2
  task automatic run_scenario(input int steps, input int mode, output bit aborted);
    int off[NC];
    bit [NC-1:0] dead;
    bit [NC-1:0] cd;
    int last_xfer, q_run, tick_at, exit_at, done_at, exp_steps, pkts_left;
    int ticks_seen, dones_seen, lat;
    bit exp_to, step_dead, exp_ready, fin, level, v, gi, ne;
    aborted = 1'b0;
    fin = 1'b0;
    dead = '0;
    if (mode == 4 || mode == 5) dead[2] = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_steps = TSW'(steps); in_valid = 1'b0; core_done = '0;
    @(posedge clk); #1;
    start = 1'b0;
    last_xfer = -1; q_run = 0; tick_at = -1; exit_at = -1; done_at = -1;
    exp_steps = 0; exp_to = 1'b0; step_dead = 1'b0; level = 1'b0;
    ticks_seen = 0; dones_seen = 0;
    pkts_left = (mode == 1) ? 4 : $urandom_range(1, 4);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (exit_at >= 0 && cyc == exit_at + 1) begin
        exp_steps++;
        if (step_dead) exp_to = 1'b1;
        if (exp_steps == steps) done_at = cyc;
        else begin
          last_xfer = -1; tick_at = -1; exit_at = -1;
          pkts_left = (mode == 1) ? 4 : $urandom_range(1, 4);
        end
      end
      if (cyc == tick_at) begin
        lat = 0;
        level = (mode == 0 || mode == 4 || mode == 5) ? 1'($urandom % 2) : 1'b0;
        for (int i = 0; i < NC; i++) begin
          if (mode == 1) off[i] = 2;
          else if (mode == 3) off[i] = (i == 5) ? 10 : 2 * i + 1;
          else off[i] = $urandom_range(0, 12);
          if (!dead[i] && off[i] > lat) lat = off[i];
        end
        step_dead = (dead != '0);
        exit_at = tick_at + (step_dead ? TO - 1 : lat);
      end
      exp_ready = (last_xfer < 0) && (done_at < 0);
      if (tick) ticks_seen++;
      if (done) dones_seen++;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++; $display("FAIL in_ready mode=%0d cyc=%0d got=%b exp=%b", mode, cyc, in_ready, exp_ready);
      end
      checks++;
      if (tick !== (cyc == tick_at)) begin
        failures++; $display("FAIL tick mode=%0d cyc=%0d got=%b exp_tick_at=%0d", mode, cyc, tick, tick_at);
      end
      checks++;
      if (done !== (cyc == done_at)) begin
        failures++; $display("FAIL done mode=%0d cyc=%0d got=%b exp_done_at=%0d", mode, cyc, done, done_at);
      end
      checks++;
      if (busy !== (done_at < 0)) begin
        failures++; $display("FAIL busy mode=%0d cyc=%0d got=%b exp=%b", mode, cyc, busy, done_at < 0);
      end
      checks++;
      if (step_cnt !== TSW'(exp_steps)) begin
        failures++; $display("FAIL step_cnt mode=%0d cyc=%0d got=%0d exp=%0d", mode, cyc, step_cnt, exp_steps);
      end
      checks++;
      if (timeout_err !== exp_to) begin
        failures++; $display("FAIL timeout_err mode=%0d cyc=%0d got=%b exp=%b", mode, cyc, timeout_err, exp_to);
      end
      if (mode == 5 && exp_steps == 1 && tick_at >= 0 && cyc == tick_at + 3) begin
        aborted = 1'b1;
        return;
      end
      if (cyc == done_at) begin
        start = 1'b0; in_valid = 1'b0; core_done = '0;
        fin = 1'b1;
        break;
      end
      // Mid-run start requests with arbitrary num_steps must be ignored.
      start = (mode == 0 || mode == 4) && ($urandom % 12 == 0);
      num_steps = TSW'($urandom_range(0, 9));
      if (exp_ready) begin
        v = (mode >= 1 && mode <= 3) ? 1'b1 : ($urandom % 3 != 0);
        in_valid = v;
        in_last = (pkts_left == 1);
        if (v) begin
          pkts_left--;
          if (pkts_left == 0) begin last_xfer = cyc; q_run = 0; end
        end
      end else begin
        in_valid = 1'($urandom % 2);
        in_last = 1'($urandom % 2);
      end
      gi = 1'b1; ne = 1'b1;
      if (mode == 0 || mode == 4 || mode == 5) begin
        lat = $urandom % 10;
        if (lat == 0) gi = 1'b0;
        else if (lat == 1) ne = 1'b0;
      end
      if (mode == 2 && exp_steps == 0 && last_xfer >= 0 && cyc == last_xfer + 4) ne = 1'b0;
      grid_idle = gi; net_empty = ne;
      if (last_xfer >= 0 && tick_at < 0 && cyc > last_xfer) begin
        q_run = (gi && ne) ? q_run + 1 : 0;
        if (q_run == ST) tick_at = cyc + 2;
      end
      cd = '0;
      if (tick_at >= 0 && cyc >= tick_at && cyc <= exit_at) begin
        for (int i = 0; i < NC; i++)
          cd[i] = !dead[i] && ((cyc == tick_at + off[i]) || (level && cyc > tick_at + off[i]));
      end else if (mode == 0 || mode == 4) begin
        cd = NC'($urandom) & NC'($urandom);
      end
      core_done = cd;
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL run_budget mode=%0d got=no_done exp=done_within_3000_cycles", mode);
      return;
    end
    @(posedge clk); #1;
    checks++;
    if (ticks_seen != steps) begin
      failures++; $display("FAIL tick_count mode=%0d got=%0d exp=%0d", mode, ticks_seen, steps);
    end
    checks++;
    if (dones_seen != 1) begin
      failures++; $display("FAIL done_count mode=%0d got=%0d exp=1", mode, dones_seen);
    end
    checks++;
    if ({done, busy, in_ready, tick} !== 4'b0 || step_cnt !== TSW'(steps) || timeout_err !== exp_to) begin
      failures++;
      $display("FAIL post_run mode=%0d got d/b/r/t=%b%b%b%b cnt=%0d to=%b exp 0000 cnt=%0d to=%b",
               mode, done, busy, in_ready, tick, step_cnt, timeout_err, steps, exp_to);
    end
    last_steps = steps;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tick, done, busy, in_ready, timeout_err} !== 5'b0 || step_cnt !== '0) begin
      failures++; $display("FAIL reset_hold got t/d/b/r/to=%b%b%b%b%b cnt=%0d exp all 0",
                           tick, done, busy, in_ready, timeout_err, step_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tick, done, busy, in_ready} !== 4'b0) begin
      failures++; $display("FAIL reset_release got t/d/b/r=%b%b%b%b exp 0000", tick, done, busy, in_ready);
    end
    last_steps = 0;
  endtask

  task automatic test_basic_run();
    bit ab;
    run_scenario(3, 1, ab);
  endtask

  task automatic test_settle_restart();
    bit ab;
    run_scenario(2, 2, ab);
  endtask

  task automatic test_staggered_acks();
    bit ab;
    run_scenario(2, 3, ab);
  endtask

  task automatic test_timeout();
    bit ab;
    run_scenario(2, 4, ab);
    run_scenario(1, 0, ab);
  endtask

  task automatic test_zero_steps();
    int ticks_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; num_steps = '0; in_valid = 1'b0; core_done = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || step_cnt !== TSW'(last_steps)) begin
      failures++; $display("FAIL zero_steps_done got d/b/r=%b%b%b cnt=%0d exp 100 cnt=%0d",
                           done, busy, in_ready, step_cnt, last_steps);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tick) ticks_seen++;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++; $display("FAIL zero_steps_after cyc=%0d got d/b/r=%b%b%b exp 000", i, done, busy, in_ready);
      end
    end
    checks++;
    if (ticks_seen != 0) begin
      failures++; $display("FAIL zero_steps_ticks got=%0d exp=0", ticks_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ab;
    run_scenario(4, 5, ab);
    checks++;
    if (!ab) begin
      failures++; $display("FAIL abort_point got=not_reached exp=reached");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tick, done, busy, in_ready, timeout_err} !== 5'b0 || step_cnt !== '0) begin
      failures++; $display("FAIL async_reset got t/d/b/r/to=%b%b%b%b%b cnt=%0d exp all 0",
                           tick, done, busy, in_ready, timeout_err, step_cnt);
    end
    start = 1'b0; in_valid = 1'b0; core_done = '0; grid_idle = 1'b1; net_empty = 1'b1;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_scenario(2, 1, ab);
  endtask

  task automatic test_random_runs();
    bit ab;
    for (int r = 0; r < 6; r++) run_scenario($urandom_range(1, 5), 0, ab);
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_settle_restart();
    test_staggered_acks();
    test_timeout();
    test_zero_steps();
    test_reset_mid_run();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
